// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic, arithmetic and shift ops plus
// multi-cycle shift-add multiply and restoring divide, with a
// valid/ready request port and a valid/ready result port.
module seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             error
);

    localparam int unsigned SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_NOR  = 4'b0100,
        OP_SLTU = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_SRA  = 4'b1010,
        OP_MUL  = 4'b1100,
        OP_DIVU = 4'b1101,
        OP_REMU = 4'b1110
    } op_t;

    state_t state;
    state_t state_next;

    logic             accept;
    logic             is_iter;
    logic             last_iter;
    logic [SW-1:0]    cnt;
    logic [3:0]       op_reg;

    // Iteration registers: product/remainder, multiplicand/quotient, multiplier/divisor
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SW-1:0]    sh;
    logic [WIDTH-1:0] sc_result;
    logic             sc_ovf;
    logic             sc_err;

    logic [WIDTH:0]   trial;
    logic             div_ok;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_a;
    logic [WIDTH-1:0] step_b;
    logic [WIDTH-1:0] iter_result;

    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt == SW'(WIDTH - 1));
    assign sum       = a + b;
    assign diff      = a - b;
    assign sh        = b[SW-1:0];

    // A zero divisor bypasses the iterative path and finishes in one cycle
    assign is_iter = (control == OP_MUL) ||
                     (((control == OP_DIVU) || (control == OP_REMU)) && (b != '0));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = is_iter ? BUSY : DONE;
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Single-cycle operation results and flags from the live inputs
    always_comb begin
        sc_result = '0;
        sc_ovf    = 1'b0;
        sc_err    = 1'b0;
        case (control)
            OP_AND:  sc_result = a & b;
            OP_OR:   sc_result = a | b;
            OP_XOR:  sc_result = a ^ b;
            OP_NOR:  sc_result = ~(a | b);
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = diff;
                sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  sc_result = a << sh;
            OP_SRL:  sc_result = a >> sh;
            OP_SRA:  sc_result = $unsigned($signed(a) >>> sh);
            OP_MUL:  sc_result = '0;
            OP_DIVU: begin
                sc_result = '1;
                sc_err    = 1'b1;
            end
            OP_REMU: begin
                sc_result = a;
                sc_err    = 1'b1;
            end
            default: begin
                sc_result = '0;
                sc_err    = 1'b1;
            end
        endcase
    end

    // One multiply or divide step; the divider shifts the dividend MSB into the remainder
    always_comb begin
        trial       = {acc, op_a[WIDTH-1]} - {1'b0, op_b};
        div_ok      = ~trial[WIDTH];
        step_acc    = acc;
        step_a      = op_a;
        step_b      = op_b;
        iter_result = '0;
        if (op_reg == OP_MUL) begin
            step_acc    = acc + (op_b[0] ? op_a : '0);
            step_a      = op_a << 1;
            step_b      = op_b >> 1;
            iter_result = step_acc;
        end else begin
            step_acc    = div_ok ? trial[WIDTH-1:0] : {acc[WIDTH-2:0], op_a[WIDTH-1]};
            step_a      = {op_a[WIDTH-2:0], div_ok};
            iter_result = (op_reg == OP_DIVU) ? step_a : step_acc;
        end
    end

    // Operand latching, iteration and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg   <= '0;
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            cnt      <= '0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_reg <= control;
                        op_a   <= a;
                        op_b   <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        if (!is_iter) begin
                            result   <= sc_result;
                            zero     <= (sc_result == '0);
                            overflow <= sc_ovf;
                            error    <= sc_err;
                        end
                    end
                end
                BUSY: begin
                    acc  <= step_acc;
                    op_a <= step_a;
                    op_b <= step_b;
                    if (last_iter) begin
                        cnt      <= '0;
                        result   <= iter_result;
                        zero     <= (iter_result == '0);
                        overflow <= 1'b0;
                        error    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, meaning datapath width; legal values are powers of two from 8 to 64.
REQ-002 SHALL provide port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port in_valid  input  1  operation request.
REQ-005 SHALL provide port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL provide port a  input  WIDTH  operand A.
REQ-007 SHALL provide port b  input  WIDTH  operand B; for shifts, the low log2(WIDTH) bits are the shift amount.
REQ-008 SHALL provide port control  input  4  operation select.
REQ-009 SHALL provide port out_valid  output  1  result available.
REQ-010 SHALL provide port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL provide port result  output  WIDTH  operation result.
REQ-012 SHALL provide port zero  output  1  result equals 0.
REQ-013 SHALL provide port overflow  output  1  signed overflow; ADD and SUB only, 0 otherwise.
REQ-014 SHALL provide port error  output  1  illegal opcode or divide-by-zero.

Function
REQ-015 SHALL decode control as follows: 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 NOR; 0101 SLTU; 0110 SUB; 0111 SLT (signed two's-complement compare, correct across sign mismatch); 1000 SLL; 1001 SRL; 1010 SRA; 1100 MUL (low WIDTH bits of the product); 1101 DIVU quotient; 1110 REMU remainder.
REQ-016 SHALL use bitwise semantics for AND, OR, XOR and NOR, never logical reduction.
REQ-017 SHALL return 1 (zero-extended) or 0 for SLT and SLTU.
REQ-018 SHALL implement a state machine with states IDLE, BUSY and DONE.
REQ-019 SHALL drive in_ready high only in IDLE.
REQ-020 SHALL latch a, b and control and accept the request when in_valid and in_ready are both high.
REQ-021 SHALL, on accepting any single-cycle op (all except 1100, 1101, 1110), go to DONE; out_valid asserts on the next cycle (latency 1).
REQ-022 SHALL, on accepting MUL, DIVU or REMU, go to BUSY and iterate one bit per cycle with a shift-add or restoring-division counter running 0..WIDTH-1.
REQ-023 SHALL go from BUSY to DONE when the counter reaches WIDTH-1; out_valid asserts exactly WIDTH+1 cycles after acceptance.
REQ-024 SHALL hold result, zero, overflow and error stable while out_valid is high and out_ready is low.
REQ-025 SHALL go from DONE to IDLE on out_valid && out_ready; in_ready rises the following cycle, with no same-cycle re-accept.
REQ-026 SHALL ignore in_valid in BUSY and DONE; operand changes in those states have no effect.
REQ-027 SHALL, when a divisor of 0 is accepted, skip iteration, go to DONE with latency 1, set error=1, and return quotient all-ones or remainder = a.
REQ-028 SHALL, for an illegal opcode (1011, 1111), go to DONE with latency 1, result=0, zero=1, error=1.
REQ-029 SHALL compute zero from the final registered result, in the same cycle that out_valid asserts.
REQ-030 SHALL set overflow for ADD when both operands have the same sign and the result sign differs.
REQ-031 SHALL set overflow for SUB when the operand signs differ and the result sign differs from a.
REQ-032 SHALL fill SRA with a[WIDTH-1]; SLL and SRL SHALL fill with 0; a shift amount of 0 returns a.

Reset
REQ-033 SHALL, when reset is high at a clock edge, enter IDLE and set out_valid=0, result=0, zero=0, overflow=0, error=0, in_ready=1 and counter=0.
REQ-034 SHALL abort any operation in BUSY or DONE on reset, discard it, and produce no out_valid for it.
REQ-035 SHALL give reset priority over every handshake event in the same cycle.

Verification
REQ-036 SHALL verify, with WIDTH=32 and out_ready=1: ADD a=0x7FFFFFFF b=1 -> after 1 cycle result=0x80000000, overflow=1, zero=0.
REQ-037 SHALL verify: SLT a=0xFFFFFFFF b=1 -> result=1; SLTU with the same operands -> result=0.
REQ-038 SHALL verify: MUL a=0x00010003 b=0x00000005 -> out_valid exactly 33 cycles after accept, result=0x0005000F, in_ready=0 throughout.
REQ-039 SHALL verify: DIVU a=100 b=0 -> after 1 cycle result=0xFFFFFFFF, error=1; REMU a=100 b=7 -> result=2, error=0.
REQ-040 SHALL verify backpressure: SUB a=5 b=5 with out_ready=0 for 4 cycles -> result=0, zero=1 held stable; accept on out_ready=1; in_ready=1 the next cycle.
REQ-041 SHALL verify: reset asserted in cycle 10 of a DIVU -> next cycle IDLE, in_ready=1, out_valid=0; a new AND a=0xF0F0 b=0xFF00 -> result=0xF000.
